// File: rtl/wb_stage_if.sv
// Bundles the write-back stage's MEM-side handshake, data-memory response
// and register-file write port. master = upstream driver, slave = the stage.
interface wb_stage_if #(
    parameter int CNT_W = 32
);
    logic             in_valid_in;
    logic             in_ready_out;
    logic [4:0]       rd_addr_in;
    logic             wr_en_in;
    logic [1:0]       wb_sel_in;
    logic [2:0]       funct3_in;
    logic [31:0]      alu_result_in;
    logic [31:0]      pc_in;
    logic [31:0]      imm_in;
    logic [31:0]      dmem_rdata_in;
    logic             dmem_rvalid_in;
    logic [4:0]       rd_addr_out;
    logic [31:0]      rd_data_out;
    logic             wr_en_out;
    logic             misalign_err_out;
    logic [CNT_W-1:0] retired_out;

    modport master (
        output in_valid_in, rd_addr_in, wr_en_in, wb_sel_in, funct3_in,
               alu_result_in, pc_in, imm_in, dmem_rdata_in, dmem_rvalid_in,
        input  in_ready_out, rd_addr_out, rd_data_out, wr_en_out,
               misalign_err_out, retired_out
    );

    modport slave (
        input  in_valid_in, rd_addr_in, wr_en_in, wb_sel_in, funct3_in,
               alu_result_in, pc_in, imm_in, dmem_rdata_in, dmem_rvalid_in,
        output in_ready_out, rd_addr_out, rd_data_out, wr_en_out,
               misalign_err_out, retired_out
    );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: selects the result source, waits for and formats load
// data, flags misaligned/illegal loads and counts retired instructions.
module wb_stage #(
    parameter int CNT_W = 32
) (
    input logic       clk_in,
    input logic       rst_in,
    wb_stage_if.slave bus
);
    typedef enum logic {IDLE, LOAD_WAIT} state_e;

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_PC4  = 2'b10;

    state_e           state_q, state_d;
    logic [4:0]       rd_addr_q, rd_addr_d;
    logic [31:0]      rd_data_q, rd_data_d;
    logic             wr_en_q, wr_en_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [4:0]       ld_rd_q, ld_rd_d;
    logic             ld_wen_q, ld_wen_d;
    logic [2:0]       ld_f3_q, ld_f3_d;
    logic [1:0]       ld_off_q, ld_off_d;

    function automatic logic load_bad(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'b000, 3'b100: load_bad = 1'b0;
            3'b001, 3'b101: load_bad = off[0];
            3'b010:         load_bad = |off;
            default:        load_bad = 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] fmt_load(input logic [31:0] word,
                                             input logic [2:0]  f3,
                                             input logic [1:0]  off);
        logic [31:0] lane;
        lane = word >> {off, 3'b000};
        case (f3)
            3'b000:  fmt_load = {{24{lane[7]}}, lane[7:0]};
            3'b001:  fmt_load = {{16{lane[15]}}, lane[15:0]};
            3'b100:  fmt_load = {24'd0, lane[7:0]};
            3'b101:  fmt_load = {16'd0, lane[15:0]};
            default: fmt_load = lane;
        endcase
    endfunction

    logic [31:0] src_data;
    logic        accept;

    assign accept = bus.in_valid_in && (state_q == IDLE);

    always_comb begin
        case (bus.wb_sel_in)
            SEL_ALU: src_data = bus.alu_result_in;
            SEL_PC4: src_data = bus.pc_in + 32'd4;
            2'b11:   src_data = bus.imm_in;
            default: src_data = bus.alu_result_in;
        endcase
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        wr_en_d   = 1'b0;
        err_d     = 1'b0;
        retired_d = retired_q;
        ld_rd_d   = ld_rd_q;
        ld_wen_d  = ld_wen_q;
        ld_f3_d   = ld_f3_q;
        ld_off_d  = ld_off_q;

        case (state_q)
            IDLE: begin
                if (accept && bus.wb_sel_in != SEL_LOAD) begin
                    wr_en_d   = bus.wr_en_in && (bus.rd_addr_in != 5'd0);
                    retired_d = retired_q + CNT_W'(1);
                    if (wr_en_d) begin
                        rd_addr_d = bus.rd_addr_in;
                        rd_data_d = src_data;
                    end
                end else if (accept) begin
                    if (load_bad(bus.funct3_in, bus.alu_result_in[1:0])) begin
                        err_d = 1'b1;
                    end else begin
                        ld_rd_d  = bus.rd_addr_in;
                        ld_wen_d = bus.wr_en_in;
                        ld_f3_d  = bus.funct3_in;
                        ld_off_d = bus.alu_result_in[1:0];
                        state_d  = LOAD_WAIT;
                    end
                end
            end
            LOAD_WAIT: begin
                if (bus.dmem_rvalid_in) begin
                    wr_en_d   = ld_wen_q && (ld_rd_q != 5'd0);
                    retired_d = retired_q + CNT_W'(1);
                    state_d   = IDLE;
                    if (wr_en_d) begin
                        rd_addr_d = ld_rd_q;
                        rd_data_d = fmt_load(bus.dmem_rdata_in, ld_f3_q, ld_off_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            rd_addr_q <= 5'd0;
            rd_data_q <= 32'd0;
            wr_en_q   <= 1'b0;
            err_q     <= 1'b0;
            retired_q <= '0;
            ld_rd_q   <= 5'd0;
            ld_wen_q  <= 1'b0;
            ld_f3_q   <= 3'd0;
            ld_off_q  <= 2'd0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
            wr_en_q   <= wr_en_d;
            err_q     <= err_d;
            retired_q <= retired_d;
            ld_rd_q   <= ld_rd_d;
            ld_wen_q  <= ld_wen_d;
            ld_f3_q   <= ld_f3_d;
            ld_off_q  <= ld_off_d;
        end
    end

    assign bus.in_ready_out     = (state_q == IDLE);
    assign bus.rd_addr_out      = rd_addr_q;
    assign bus.rd_data_out      = rd_data_q;
    assign bus.wr_en_out        = wr_en_q;
    assign bus.misalign_err_out = err_q;
    assign bus.retired_out      = retired_q;
endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: ALU/PC+4/imm results, load wait and
// formatting, misaligned/illegal loads, counter wrap and reset behaviour.
module tb_wb_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_stage_if #(.CNT_W(32)) bus ();
    wb_stage_if #(.CNT_W(4))  bus4 ();

    wb_stage #(.CNT_W(32)) dut  (.clk_in(clk), .rst_in(rst), .bus(bus));
    wb_stage #(.CNT_W(4))  dut4 (.clk_in(clk), .rst_in(rst), .bus(bus4));

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] sel, input logic [4:0] rd, input logic wen,
                        input logic [2:0] f3, input logic [31:0] alu,
                        input logic [31:0] pc, input logic [31:0] imm);
        bus.in_valid_in   = 1'b1;
        bus.wb_sel_in     = sel;
        bus.rd_addr_in    = rd;
        bus.wr_en_in      = wen;
        bus.funct3_in     = f3;
        bus.alu_result_in = alu;
        bus.pc_in         = pc;
        bus.imm_in        = imm;
    endtask

    // Accepts a load (with a decoy rvalid in the accept cycle), then waits
    // wait_n cycles with ready low, returning data in the last of them.
    task automatic do_load(input logic [2:0] f3, input logic [1:0] off, input logic [4:0] rd,
                           input logic wen, input logic [31:0] rdata, input int wait_n);
        send(2'b01, rd, wen, f3, {30'd0, off}, 32'd0, 32'd0);
        bus.dmem_rvalid_in = 1'b1;
        bus.dmem_rdata_in  = 32'h1111_1111;
        step();
        bus.in_valid_in    = 1'b0;
        bus.dmem_rvalid_in = 1'b0;
        for (int i = 0; i < wait_n; i++) begin
            check("ld_ready_low", bus.in_ready_out, 1'b0);
            check("ld_no_write", bus.wr_en_out, 1'b0);
            if (i == wait_n - 1) begin
                bus.dmem_rvalid_in = 1'b1;
                bus.dmem_rdata_in  = rdata;
            end
            step();
        end
        bus.dmem_rvalid_in = 1'b0;
    endtask

    initial begin
        bus.dmem_rvalid_in = 1'b0;
        bus.dmem_rdata_in  = 32'd0;
        bus4.in_valid_in   = 1'b0;
        bus4.rd_addr_in    = 5'd1;
        bus4.wr_en_in      = 1'b1;
        bus4.wb_sel_in     = 2'b00;
        bus4.funct3_in     = 3'd0;
        bus4.alu_result_in = 32'h0000_0042;
        bus4.pc_in         = 32'd0;
        bus4.imm_in        = 32'd0;
        bus4.dmem_rdata_in = 32'd0;
        bus4.dmem_rvalid_in = 1'b0;

        // Reset wins over a simultaneous acceptance.
        send(2'b00, 5'd5, 1'b1, 3'd0, 32'hDEAD_0001, 32'd0, 32'd0);
        step();
        step();
        rst = 1'b0;
        bus.in_valid_in = 1'b0;
        check("rst_wr_en", bus.wr_en_out, 1'b0);
        check("rst_err", bus.misalign_err_out, 1'b0);
        check("rst_rd_addr", bus.rd_addr_out, 32'd0);
        check("rst_rd_data", bus.rd_data_out, 32'd0);
        check("rst_retired", bus.retired_out, 32'd0);
        check("rst_ready", bus.in_ready_out, 1'b1);

        // Single ALU op.
        send(2'b00, 5'd5, 1'b1, 3'd0, 32'h1234_5678, 32'd0, 32'd0);
        step();
        bus.in_valid_in = 1'b0;
        check("alu_wr_en", bus.wr_en_out, 1'b1);
        check("alu_rd_addr", bus.rd_addr_out, 32'd5);
        check("alu_rd_data", bus.rd_data_out, 32'h1234_5678);
        check("alu_retired", bus.retired_out, 32'd1);
        step();
        check("alu_pulse_end", bus.wr_en_out, 1'b0);
        check("alu_data_hold", bus.rd_data_out, 32'h1234_5678);

        // Back-to-back ALU, PC+4 (wrapping) and immediate.
        send(2'b00, 5'd1, 1'b1, 3'd0, 32'hDEAD_BEEF, 32'd0, 32'd0);
        step();
        check("b2b1_data", bus.rd_data_out, 32'hDEAD_BEEF);
        check("b2b1_ready", bus.in_ready_out, 1'b1);
        send(2'b10, 5'd2, 1'b1, 3'd0, 32'h0000_0000, 32'hFFFF_FFFC, 32'd0);
        step();
        check("b2b2_wr_en", bus.wr_en_out, 1'b1);
        check("b2b2_rd_addr", bus.rd_addr_out, 32'd2);
        check("b2b2_data", bus.rd_data_out, 32'h0000_0000);
        check("b2b2_ready", bus.in_ready_out, 1'b1);
        send(2'b11, 5'd3, 1'b1, 3'd0, 32'h0000_0000, 32'd0, 32'hABCD_E000);
        step();
        bus.in_valid_in = 1'b0;
        check("b2b3_wr_en", bus.wr_en_out, 1'b1);
        check("b2b3_data", bus.rd_data_out, 32'hABCD_E000);
        check("b2b3_retired", bus.retired_out, 32'd4);
        step();
        check("b2b_end", bus.wr_en_out, 1'b0);

        // Loads: LB, LBU, LHU, LH, LW.
        do_load(3'b000, 2'd3, 5'd7, 1'b1, 32'h80FF_FFFF, 4);
        check("lb_wr_en", bus.wr_en_out, 1'b1);
        check("lb_rd_addr", bus.rd_addr_out, 32'd7);
        check("lb_data", bus.rd_data_out, 32'hFFFF_FF80);
        check("lb_ready", bus.in_ready_out, 1'b1);
        check("lb_retired", bus.retired_out, 32'd5);
        do_load(3'b100, 2'd3, 5'd7, 1'b1, 32'h80FF_FFFF, 4);
        check("lbu_data", bus.rd_data_out, 32'h0000_0080);
        do_load(3'b101, 2'd2, 5'd8, 1'b1, 32'h8001_0000, 2);
        check("lhu_data", bus.rd_data_out, 32'h0000_8001);
        check("lhu_rd_addr", bus.rd_addr_out, 32'd8);
        do_load(3'b001, 2'd2, 5'd9, 1'b1, 32'h8001_0000, 1);
        check("lh_data", bus.rd_data_out, 32'hFFFF_8001);
        do_load(3'b010, 2'd0, 5'd10, 1'b1, 32'hCAFE_F00D, 3);
        check("lw_data", bus.rd_data_out, 32'hCAFE_F00D);
        check("lw_retired", bus.retired_out, 32'd9);

        // Misaligned / illegal loads, back to back.
        send(2'b01, 5'd11, 1'b1, 3'b010, 32'h0000_0002, 32'd0, 32'd0);
        step();
        check("lw_mis_err", bus.misalign_err_out, 1'b1);
        check("lw_mis_wr", bus.wr_en_out, 1'b0);
        check("lw_mis_ready", bus.in_ready_out, 1'b1);
        send(2'b01, 5'd11, 1'b1, 3'b011, 32'h0000_0000, 32'd0, 32'd0);
        step();
        check("ill_err", bus.misalign_err_out, 1'b1);
        check("ill_wr", bus.wr_en_out, 1'b0);
        send(2'b01, 5'd11, 1'b1, 3'b001, 32'h0000_0001, 32'd0, 32'd0);
        step();
        bus.in_valid_in = 1'b0;
        check("lh_mis_err", bus.misalign_err_out, 1'b1);
        check("mis_retired", bus.retired_out, 32'd9);
        check("mis_ready", bus.in_ready_out, 1'b1);

        // rvalid while idle is ignored.
        bus.dmem_rvalid_in = 1'b1;
        bus.dmem_rdata_in  = 32'h5555_5555;
        step();
        bus.dmem_rvalid_in = 1'b0;
        check("idle_rv_err", bus.misalign_err_out, 1'b0);
        check("idle_rv_wr", bus.wr_en_out, 1'b0);
        check("idle_rv_hold", bus.rd_data_out, 32'hCAFE_F00D);
        check("idle_rv_ret", bus.retired_out, 32'd9);

        // rd=0 and wr_en=0 still retire, but do not write.
        send(2'b00, 5'd0, 1'b1, 3'd0, 32'h0000_5555, 32'd0, 32'd0);
        step();
        check("rd0_wr", bus.wr_en_out, 1'b0);
        check("rd0_addr_hold", bus.rd_addr_out, 32'd10);
        check("rd0_retired", bus.retired_out, 32'd10);
        send(2'b00, 5'd4, 1'b0, 3'd0, 32'h0000_7777, 32'd0, 32'd0);
        step();
        bus.in_valid_in = 1'b0;
        check("wen0_wr", bus.wr_en_out, 1'b0);
        check("wen0_retired", bus.retired_out, 32'd11);
        do_load(3'b010, 2'd0, 5'd0, 1'b1, 32'h1234_0000, 1);
        check("ld_rd0_wr", bus.wr_en_out, 1'b0);
        check("ld_rd0_hold", bus.rd_data_out, 32'hCAFE_F00D);
        check("ld_rd0_retired", bus.retired_out, 32'd12);

        // Narrow counter wraps after 16 retirements.
        bus4.in_valid_in = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            if (i == 15) check("wrap_15", bus4.retired_out, 32'd15);
            if (i == 16) check("wrap_0", bus4.retired_out, 32'd0);
        end
        bus4.in_valid_in = 1'b0;

        // Reset in LOAD_WAIT abandons the load.
        send(2'b01, 5'd9, 1'b1, 3'b000, 32'h0000_0000, 32'd0, 32'd0);
        step();
        bus.in_valid_in = 1'b0;
        check("pre_rst_ready", bus.in_ready_out, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("lw_rst_ready", bus.in_ready_out, 1'b1);
        check("lw_rst_addr", bus.rd_addr_out, 32'd0);
        check("lw_rst_data", bus.rd_data_out, 32'd0);
        check("lw_rst_retired", bus.retired_out, 32'd0);
        bus.dmem_rvalid_in = 1'b1;
        bus.dmem_rdata_in  = 32'h0000_00FF;
        step();
        bus.dmem_rvalid_in = 1'b0;
        check("post_rst_wr", bus.wr_en_out, 1'b0);
        check("post_rst_err", bus.misalign_err_out, 1'b0);
        check("post_rst_data", bus.rd_data_out, 32'd0);
        check("post_rst_retired", bus.retired_out, 32'd0);
        check("post_rst_ready", bus.in_ready_out, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
